// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: DVP capture sequencer in the dvp_pclk domain.
// Arms the capture stage, counts bytes per line and lines per frame, and
// reports good frames (frame_done) or failures (sticky frame_err/err_code).
// Optional arm timeout: define FRAME_CAPTURE_CTRL_TIMEOUT_EN to build it.
module frame_capture_ctrl #(
    parameter int unsigned LINE_BYTES     = 1280,
    parameter int unsigned FRAME_LINES    = 480,
    parameter int unsigned TIMEOUT_CYCLES = 12500000
) (
    input  logic        dvp_pclk,
    input  logic        rst_n,
    input  logic        ip_enable,
    input  logic        start,
    input  logic        continuous,
    input  logic        img_start,
    input  logic        fifo_write,
    input  logic        fifo_full,
    output logic        capture_enable,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [10:0] line_cnt,
    output logic [11:0] byte_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_OVF   = 2'b01;
    localparam logic [1:0]  ERR_LINE  = 2'b10;
    localparam logic [1:0]  ERR_TMO   = 2'b11;
    localparam logic [11:0] LINE_LEN  = 12'(LINE_BYTES);
    localparam logic [10:0] LAST_LINE = 11'(FRAME_LINES);

    state_t      state;
    state_t      state_nx;
    logic        err_nx;
    logic [1:0]  code_nx;
    logic [10:0] line_nx;
    logic [11:0] byte_nx;
    logic [10:0] line_inc;
    logic        fifo_write_d;
    logic        line_end;
    logic        overflow;
    logic        tmo_hit;

    assign line_inc = line_cnt + 11'd1;
    assign line_end = fifo_write_d && !fifo_write;
    assign overflow = fifo_write && fifo_full;

`ifdef FRAME_CAPTURE_CTRL_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Arm timeout counter: cleared when ARM is entered, counts while in ARM.
    always_ff @(posedge dvp_pclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_nx == S_ARM && state != S_ARM) begin
            tmo_cnt <= '0;
        end else if (state == S_ARM) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Timeout must be non-zero and fit the 24-bit arm counter.
    a_timeout_range : assert property (@(posedge dvp_pclk) disable iff (!rst_n)
        (TIMEOUT_CYCLES >= 32'd1) && (TIMEOUT_CYCLES <= 32'd16777216));

    // Next-state, error and counter logic; priority is ip_enable low,
    // then overflow, then line-end check, then frame completion.
    always_comb begin
        state_nx = state;
        err_nx   = frame_err;
        code_nx  = err_code;
        line_nx  = line_cnt;
        byte_nx  = byte_cnt;
        unique case (state)
            S_IDLE: begin
                if (ip_enable && start) begin
                    state_nx = S_ARM;
                    err_nx   = 1'b0;
                    code_nx  = ERR_NONE;
                    line_nx  = '0;
                    byte_nx  = '0;
                end
            end
            S_ARM: begin
                if (!ip_enable) begin
                    state_nx = S_IDLE;
                end else if (overflow) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                    code_nx  = ERR_OVF;
                end else if (img_start) begin
                    state_nx = S_ACTIVE;
                    line_nx  = '0;
                    byte_nx  = '0;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                    code_nx  = ERR_TMO;
                end
            end
            S_ACTIVE: begin
                if (!ip_enable) begin
                    state_nx = S_IDLE;
                end else if (overflow) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                    code_nx  = ERR_OVF;
                end else if (line_end) begin
                    if (byte_cnt != LINE_LEN) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                        code_nx  = ERR_LINE;
                    end else begin
                        line_nx = line_inc;
                        byte_nx = '0;
                        if (line_inc == LAST_LINE) begin
                            state_nx = S_DONE;
                        end
                    end
                end else if (fifo_write && byte_cnt != '1) begin
                    byte_nx = byte_cnt + 12'd1;
                end
            end
            S_DONE: begin
                if (continuous && ip_enable) begin
                    state_nx = S_ARM;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge dvp_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            capture_enable <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            err_code       <= ERR_NONE;
            line_cnt       <= '0;
            byte_cnt       <= '0;
            fifo_write_d   <= 1'b0;
        end else begin
            state          <= state_nx;
            capture_enable <= (state_nx == S_ARM) || (state_nx == S_ACTIVE);
            busy           <= (state_nx != S_IDLE);
            frame_done     <= (state_nx == S_DONE);
            frame_err      <= err_nx;
            err_code       <= code_nx;
            line_cnt       <= line_nx;
            byte_cnt       <= byte_nx;
            fifo_write_d   <= fifo_write;
        end
    end

endmodule
